// File: rtl/dmem_arbiter.sv
// Data RAM arbiter: CPU port has fixed priority and a same-cycle read path;
// DMA port is starvation-protected and receives registered read data.
module dmem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             c_req,
   input  logic             c_wr,
   input  logic [31:0]      c_addr,
   input  logic [31:0]      c_wdata,
   output logic             c_stall,
   output logic [31:0]      c_rdata,
   input  logic             d_req,
   input  logic             d_wr,
   input  logic [31:0]      d_addr,
   input  logic [31:0]      d_wdata,
   output logic             d_gnt,
   output logic             d_rvalid,
   output logic [31:0]      d_rdata,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic {NORM, FORCE} state_t;

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wcnt;
   logic [7:0] wcnt_nxt;
   logic       c_gnt;
   logic       d_rd_gnt;

   always_comb begin
      c_gnt     = 1'b0;
      d_gnt     = 1'b0;
      wcnt_nxt  = wcnt;
      state_nxt = state;
      // Reset masks every grant so no RAM write can slip through.
      if (!rst) begin
         case (state)
            NORM: begin
               c_gnt = c_req;
               d_gnt = d_req & ~c_req;
            end
            FORCE: begin
               d_gnt = d_req;
               c_gnt = c_req & ~d_req;
            end
            default: begin
               c_gnt = 1'b0;
               d_gnt = 1'b0;
            end
         endcase
      end
      if (d_req & c_req & ~d_gnt)
         wcnt_nxt = (wcnt >= LIMIT) ? LIMIT : wcnt + 8'd1;
      else if (d_gnt | ~d_req)
         wcnt_nxt = 8'd0;
      case (state)
         NORM:    if (wcnt_nxt == LIMIT) state_nxt = FORCE;
         FORCE:   if (d_gnt | ~d_req) state_nxt = NORM;
         default: state_nxt = NORM;
      endcase
   end

   assign d_rd_gnt  = d_gnt & ~d_wr;
   assign mem_rd    = (c_gnt & ~c_wr) | d_rd_gnt;
   assign mem_wr    = (c_gnt & c_wr) | (d_gnt & d_wr);
   assign mem_addr  = c_gnt ? c_addr  : (d_gnt ? d_addr  : 32'd0);
   assign mem_wdata = c_gnt ? c_wdata : (d_gnt ? d_wdata : 32'd0);
   assign c_stall   = c_req & ~c_gnt;
   assign c_rdata   = (c_gnt & ~c_wr) ? mem_rdata : 32'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= NORM;
         wcnt      <= 8'd0;
         d_rvalid  <= 1'b0;
         d_rdata   <= 32'd0;
         stall_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wcnt     <= wcnt_nxt;
         d_rvalid <= d_rd_gnt;
         if (d_rd_gnt)
            d_rdata <= mem_rdata;
         if (c_stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
